// File: rtl/arb_mux_reg.sv
// arb_mux_reg: registered N-channel selector with valid/ready handshakes; ARB_MUX_RR_EN selects round-robin arbitration
module arb_mux_reg #(
  parameter int WIDTH = 5,
  parameter int N = 3,
  localparam int SELW = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N*WIDTH-1:0] i_data,
  input  logic [N-1:0]       i_valid,
  output logic [N-1:0]       o_ready,
  input  logic               i_mode,
  input  logic [SELW-1:0]    i_sel,
  output logic [WIDTH-1:0]   o_data,
  output logic [SELW-1:0]    o_src,
  output logic               o_valid,
  input  logic               i_ready
);
  logic [SELW-1:0] rr_ptr, gnt, cand;
  logic gnt_v, load_en, xfer;
  int idx;
  always_comb begin
    load_en = !o_valid || i_ready;
    cand = (32'(i_sel) >= N) ? '0 : i_sel;
    idx = 0;
    gnt = cand;
    gnt_v = i_mode && i_valid[cand];
    if (!i_mode)
      for (int j = 0; j < N; j++) begin
`ifdef ARB_MUX_RR_EN
        idx = int'(rr_ptr) + j;
        idx = (idx >= N) ? idx - N : idx;
`else
        idx = j;
`endif
        if (!gnt_v && i_valid[idx]) begin
          gnt = SELW'(idx);
          gnt_v = 1'b1;
        end
      end
    o_ready = '0;
    if (i_rst_n && load_en && gnt_v) o_ready[gnt] = 1'b1;
    xfer = |(i_valid & o_ready);
  end
  // rr_ptr advances in both builds; only the round-robin search reads it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_data <= '0;
      o_src <= '0;
      o_valid <= 1'b0;
      rr_ptr <= '0;
    end else if (xfer) begin
      o_data <= i_data[32'(gnt)*WIDTH +: WIDTH];
      o_src <= gnt;
      o_valid <= 1'b1;
      rr_ptr <= (32'(gnt) == N - 1) ? '0 : gnt + SELW'(1);
    end else if (i_ready)
      o_valid <= 1'b0;
endmodule

// File: tb/tb_arb_mux_reg.sv
// tb_arb_mux_reg: directed vectors with a scoreboard queue popped by a monitor on each consumed output word
module tb_arb_mux_reg;
  logic clk = 0, rst_n = 0;
  logic [14:0] data = {5'h1F, 5'h0A, 5'h03};
  logic [2:0] valid = 3'b111, ready_o;
  logic mode = 0, ready_i = 1, o_valid;
  logic [1:0] sel = 0, o_src;
  logic [4:0] o_data;
  logic [6:0] q[$];
  int total = 0, passes = 0;

`ifdef ARB_MUX_RR_EN
  localparam logic [4:0] HELD_D = 5'h1F;
  localparam logic [1:0] HELD_S = 2'd2;
`else
  localparam logic [4:0] HELD_D = 5'h03;
  localparam logic [1:0] HELD_S = 2'd0;
`endif

  arb_mux_reg dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(ready_o),
    .i_mode(mode), .i_sel(sel), .o_data(o_data), .o_src(o_src), .o_valid(o_valid),
    .i_ready(ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [4:0] chd(input int k);
    return k == 0 ? 5'h03 : k == 1 ? 5'h0A : 5'h1F;
  endfunction

  task automatic cyc(input logic [2:0] v, input logic m, input logic [1:0] s, input logic r,
                     input logic [2:0] erdy, input logic push, input logic [4:0] ed, input logic [1:0] es);
    @(posedge clk);
    #1 valid = v; mode = m; sel = s; ready_i = r;
    #1 chk("o_ready", ready_o, erdy);
    if (push) q.push_back({ed, es});
  endtask

  always @(negedge clk)
    if (rst_n && o_valid && ready_i) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_word: got data %0h src %0d, expected no word", o_data, o_src);
      end else begin
        logic [6:0] e;
        e = q.pop_front();
        chk("mon_data", o_data, e[6:2]);
        chk("mon_src", o_src, e[1:0]);
      end
    end

  initial begin
    #100000 $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    #3 chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_src", o_src, 0);
    chk("rst_ready", ready_o, 0);
    @(negedge clk);
    valid = 0;
    rst_n = 1;
    cyc(3'b111, 1, 2, 1, 3'b100, 1, 5'h1F, 2);
    cyc(3'b111, 1, 3, 1, 3'b001, 1, 5'h03, 0);
    cyc(3'b101, 1, 1, 1, 3'b000, 0, 0, 0);
    cyc(3'b000, 0, 0, 1, 3'b000, 0, 0, 0);
    chk("fs_nv_ovalid", o_valid, 0);
    cyc(3'b010, 1, 1, 1, 3'b010, 1, 5'h0A, 1);
    cyc(3'b010, 1, 1, 0, 3'b000, 0, 0, 0);
    chk("hold_ovalid", o_valid, 1);
    #1 rst_n = 0;
    valid = 0;
    #1 chk("midrst_valid", o_valid, 0);
    chk("midrst_data", o_data, 0);
    chk("midrst_src", o_src, 0);
    chk("midrst_ready", ready_o, 0);
    q.delete();
    @(negedge clk);
    #1 rst_n = 1;
    for (int k = 0; k < 6; k++)
`ifdef ARB_MUX_RR_EN
      cyc(3'b111, 0, 0, 1, 3'(1 << (k % 3)), 1, chd(k % 3), 2'(k % 3));
`else
      cyc(3'b111, 0, 0, 1, 3'b001, 1, chd(0), 2'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      cyc(3'b111, 1, 1, 0, 3'b000, 0, 0, 0);
      chk("bp_data", o_data, HELD_D);
      chk("bp_src", o_src, HELD_S);
    end
    cyc(3'b111, 1, 1, 1, 3'b010, 1, 5'h0A, 1);
    cyc(3'b000, 0, 0, 1, 3'b000, 0, 0, 0);
    chk("no_bubble_ovalid", o_valid, 1);
    cyc(3'b000, 0, 0, 1, 3'b000, 0, 0, 0);
    chk("drain_ovalid", o_valid, 0);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/arb_mux_reg.md
# arb_mux_reg

Registered, parametrised N-channel, WIDTH-bit selector with per-channel valid/ready handshakes and a one-entry output buffer. It replaces fixed combinational 3:1 selection on the register-address and writeback paths, where several producers (ALU, load unit, link/return) compete for one destination port. It supports two modes:
- **Forced select:** the channel is chosen by an external select.
- **Arbitrated:** the channel is chosen by the block.

The selected word is registered with its source index, so downstream stages see a stable value until they accept it.

## Interface
Parameters:
- WIDTH, 5, data width per channel
- N, 3, number of input channels (2..16)
- SELW (localparam), $clog2(N), width of select/source index

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- i_valid  input  N  channel k offers a word
- o_ready  output  N  channel k's word is accepted this cycle
- i_mode  input  1  1 = forced select, 0 = arbitrate
- i_sel  input  SELW  channel index used in forced-select mode
- o_data  output  WIDTH  buffered selected word
- o_src  output  SELW  index of the channel that supplied o_data
- o_valid  output  1  buffer holds a word
- i_ready  input  1  downstream accepts o_data this cycle

## Operation
- **State:** buffer (o_data, o_src, o_valid) and round-robin pointer rr_ptr (SELW bits).
- **Load enable:** load_en = !o_valid || i_ready (buffer empty or draining this cycle).
- **Forced select (i_mode=1):**
  - The candidate is i_sel.
  - An out-of-range i_sel (>= N) maps to channel 0.
  - A grant is issued only if i_valid[candidate]=1. No other channel is granted.
- **Arbitrate (i_mode=0):** the grant goes to the first channel with i_valid=1, searched per the Configuration section.
- **Handshake:**
  - o_ready[k] = load_en && grant valid && grant==k. At most one bit is set per cycle.
  - o_ready is combinational from i_valid, i_mode, i_sel, i_ready and state.
  - A transfer occurs when i_valid[k] && o_ready[k].
- **On transfer:** o_data <= channel k data, o_src <= k, o_valid <= 1.
- **Drain without transfer:** if o_valid && i_ready and no channel is granted, o_valid <= 0. o_data and o_src hold their last values.
- **Hold:** if o_valid && !i_ready, the buffer holds and every o_ready bit is 0.
- **Simultaneous drain and load:** the buffer is replaced in the same edge, with no bubble.
- **rr_ptr:** updates to (grant+1) mod N on every transfer, in either mode. It is unchanged otherwise. Wrap is from N-1 to 0.
- **Mode or i_sel change while the buffer is full:** the held word is unaffected. The new mode or select applies at the next load.

## Timing
- **Reset values:** o_valid=0, o_data=0, o_src=0, rr_ptr=0. All o_ready bits are 0 while i_rst_n=0.
- **Reset assertion mid-transfer:** state clears immediately, without waiting for a clock edge, and the in-flight word is discarded.
- **Reset release:** the first arbitration starts searching at channel 0.
- **Latency:** 1 cycle. A word accepted at edge t is on o_data with o_valid=1 after edge t.
- **Throughput:** 1 word per cycle while i_ready=1 and any channel is valid.
- **Backpressure:** with i_ready=0 and o_valid=1, no channel is accepted and o_data/o_src are stable.

## Configuration
- **ARB_MUX_RR_EN defined:** arbitrate mode uses round-robin. The search starts at rr_ptr and wraps from N-1 to 0, so the last-granted channel gets lowest priority.
- **ARB_MUX_RR_EN not defined:**
  - Arbitrate mode uses fixed priority, where the lowest index wins.
  - rr_ptr is still present and updated but has no effect on the grant.
  - Forced-select behaviour is identical in both builds.

## Test plan
- **Reset:** drive i_rst_n=0 mid-stream with o_valid=1 → o_valid, o_data, o_src drop to 0 before the next edge. After release with all three channels valid, the first grant is channel 0.
- **Forced select (WIDTH=5, N=3):**
  - i_mode=1, i_sel=2, channel data 5'h03/5'h0A/5'h1F, all valid, i_ready=1 → next cycle o_data=5'h1F, o_src=2. Only o_ready[2] was set.
  - With i_sel=3 the next cycle gives o_data=5'h03, o_src=0.
- **Forced select, candidate not valid:** i_mode=1, i_sel=1, i_valid=3'b101 → no o_ready bit set. After one edge with i_ready=1, o_valid=0.
- **Round-robin (ARB_MUX_RR_EN defined):** i_mode=0, all valid, i_ready=1 for 6 cycles → o_src sequence 0,1,2,0,1,2.
- **Fixed priority (ARB_MUX_RR_EN not defined):** same stimulus as round-robin → o_src sequence 0,0,0,0,0,0.
- **Backpressure:** i_ready=0 for 3 cycles with o_valid=1 → o_data and o_src are stable and all o_ready are 0. On the cycle i_ready returns to 1, a new word is loaded in the same edge, with no bubble.
